pulse_reset_gen: RTL and testbench

- Consumes the one-cycle rising-edge pulse from the edge-detect stage of the start_to_reset path and turns it into a timed soft reset.
- Sequence: optional programmable delay, a soft reset asserted for a fixed number of cycles, then a hold-off window during which new pulses are ignored and counted.
- Drives local soft-reset domains and reports busy/done status to control logic.

---
 rtl/pulse_reset_pkg.sv | 14 +
 rtl/pulse_reset_gen_phase_cnt.sv | 26 ++
 rtl/pulse_reset_gen.sv | 121 ++++++++++++
 tb/tb_pulse_reset_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_reset_pkg.sv
// rtl/pulse_reset_pkg.sv - shared state encodings and drop-counter limits for pulse_reset_gen
package pulse_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/pulse_reset_gen_phase_cnt.sv
// rtl/pulse_reset_gen_phase_cnt.sv - phase counter with load-zero and terminal-count compare
module phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc_o = (cnt == limit_i);

endmodule

// File: rtl/pulse_reset_gen.sv
// rtl/pulse_reset_gen.sv - turns an edge-detected start pulse into a delayed, timed soft reset
module pulse_reset_gen
  import pulse_reset_pkg::*;
#(
  parameter int DELAY_CYC   = 4,
  parameter int ASSERT_CYC  = 16,
  parameter int HOLDOFF_CYC = 8,
  parameter int CNT_W       = 16
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              pulse_i,
  input  logic              drop_clr_i,
  output logic              soft_rst_o,
  output logic              soft_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'((DELAY_CYC   > 0) ? DELAY_CYC   - 1 : 0);
  localparam logic [CNT_W-1:0] AST_LIM = CNT_W'((ASSERT_CYC  > 0) ? ASSERT_CYC  - 1 : 0);
  localparam logic [CNT_W-1:0] HLD_LIM = CNT_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

  state_e           state;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_tc;
  logic             cnt_clr;

  always_comb begin
    cnt_limit = '0;
    case (state)
      ST_DELAY:   cnt_limit = DLY_LIM;
      ST_ASSERT:  cnt_limit = AST_LIM;
      ST_HOLDOFF: cnt_limit = HLD_LIM;
      default:    cnt_limit = '0;
    endcase
  end

  // Counter restarts from zero at every phase boundary and is parked in IDLE.
  assign cnt_clr = (state == ST_IDLE) || cnt_tc;

  phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (cnt_clr),
    .limit_i   (cnt_limit),
    .tc_o      (cnt_tc)
  );

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      soft_rst_o   <= 1'b0;
      soft_rst_n_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pulse_i) begin
            busy_o <= 1'b1;
            if (DELAY_CYC > 0) begin
              state <= ST_DELAY;
            end else begin
              state        <= ST_ASSERT;
              soft_rst_o   <= 1'b1;
              soft_rst_n_o <= 1'b0;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_tc) begin
            state        <= ST_ASSERT;
            soft_rst_o   <= 1'b1;
            soft_rst_n_o <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (cnt_tc) begin
            soft_rst_o   <= 1'b0;
            soft_rst_n_o <= 1'b1;
            if (HOLDOFF_CYC > 0) begin
              state <= ST_HOLDOFF;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (cnt_tc) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          soft_rst_o   <= 1'b0;
          soft_rst_n_o <= 1'b1;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle drop; count sticks at DROP_MAX.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_o <= '0;
    end else if (drop_clr_i) begin
      drop_cnt_o <= '0;
    end else if (pulse_i && (state != ST_IDLE) && (drop_cnt_o != DROP_MAX)) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_reset_gen.sv
// tb/tb_pulse_reset_gen.sv - scoreboard bench for pulse_reset_gen, default and minimal parameter sets
module tb_pulse_reset_gen;

  logic       sys_clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       pulse_i = 1'b0;
  logic       drop_clr_i = 1'b0;
  logic       srst0, srstn0, busy0, done0;
  logic       srst1, srstn1, busy1, done1;
  logic [7:0] drop0, drop1;

  always #5 sys_clk_i = ~sys_clk_i;

  pulse_reset_gen u_dut_dflt (
    .sys_clk_i    (sys_clk_i),
    .rst_n_i      (rst_n_i),
    .pulse_i      (pulse_i),
    .drop_clr_i   (drop_clr_i),
    .soft_rst_o   (srst0),
    .soft_rst_n_o (srstn0),
    .busy_o       (busy0),
    .done_o       (done0),
    .drop_cnt_o   (drop0)
  );

  pulse_reset_gen #(.DELAY_CYC(0), .ASSERT_CYC(1), .HOLDOFF_CYC(0), .CNT_W(16)) u_dut_min (
    .sys_clk_i    (sys_clk_i),
    .rst_n_i      (rst_n_i),
    .pulse_i      (pulse_i),
    .drop_clr_i   (drop_clr_i),
    .soft_rst_o   (srst1),
    .soft_rst_n_o (srstn1),
    .busy_o       (busy1),
    .done_o       (done1),
    .drop_cnt_o   (drop1)
  );

  typedef struct {
    int         cyc;
    logic [3:0] obs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   p_d[2] = '{4, 0};
  int   p_a[2] = '{16, 1};
  int   p_h[2] = '{8, 0};
  int   free_at[2] = '{0, 0};
  int   drop_exp[2] = '{0, 0};

  // Expected {busy, soft_rst, soft_rst_n, done} for every cycle of a sequence started at t.
  task automatic launch(input int d, input int t);
    int l;
    l = p_d[d] + p_a[d] + p_h[d];
    for (int k = t + 1; k <= t + l + 1; k++) begin
      exp_t e;
      logic b, s, dn;
      b  = (k <= t + l);
      s  = (k >= t + 1 + p_d[d]) && (k <= t + p_d[d] + p_a[d]);
      dn = (k == t + l + 1);
      e.cyc = k;
      e.obs = {b, s, ~s, dn};
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    free_at[d] = t + l + 1;
  endtask

  task automatic check_dut(input int d, input logic [3:0] obs, input logic [7:0] drop);
    logic [3:0] want;
    exp_t       e;
    want = 4'b0010;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        want = e.obs;
      end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        want = e.obs;
      end
    end
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL seq_out dut%0d cyc=%0d busy/srst/srst_n/done got=%b want=%b", d, cyc, obs, want);
    end
    vectors++;
    assert (drop === 8'(drop_exp[d])) else begin
      miscompares++;
      $error("FAIL drop_cnt dut%0d cyc=%0d got=%0d want=%0d", d, cyc, drop, drop_exp[d]);
    end
  endtask

  task automatic model(input int d, input logic p, input logic clr);
    logic acc;
    acc = p && (cyc >= free_at[d]);
    if (acc) launch(d, cyc);
    if (clr)                            drop_exp[d] = 0;
    else if (p && !acc && drop_exp[d] < 255) drop_exp[d]++;
  endtask

  task automatic step(input logic p, input logic clr, input logic rn);
    @(posedge sys_clk_i);
    cyc++;
    #1;
    pulse_i    = p;
    drop_clr_i = clr;
    rst_n_i    = rn;
    #1;
    if (!rn) begin
      q0.delete();
      q1.delete();
      free_at  = '{0, 0};
      drop_exp = '{0, 0};
    end
    check_dut(0, {busy0, srst0, srstn0, done0}, drop0);
    check_dut(1, {busy1, srst1, srstn1, done1}, drop1);
    if (rn) begin
      model(0, p, clr);
      model(1, p, clr);
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c - 1) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pulse_at(input int c);
    run_to(c);
    step(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // single sequence, then minimal-parameter timing
    restart();
    pulse_at(10);
    run_to(46);
    restart();
    pulse_at(5);
    run_to(12);

    // drops while busy, pulse accepted in the done cycle
    restart();
    pulse_at(10);
    pulse_at(20);
    pulse_at(35);
    pulse_at(39);
    run_to(75);

    // reset mid-sequence
    restart();
    pulse_at(10);
    run_to(20);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pulse_at(30);
    run_to(62);

    // pulse held high across several IDLE/DELAY cycles
    restart();
    run_to(10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    run_to(45);

    // drop saturation, then clear together with a dropped pulse
    restart();
    for (int i = 0; i < 600; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
